stream_mux_rr: RTL and testbench

- Parametrised N-input, W-bit multiplexer with a valid/ready handshake on every input and on the output.
- The output is held in a one-entry pipeline register.
- Two modes:
  - Fixed mode: explicit select.
  - Round-robin mode: a fair rotating grant across all valid inputs.
- Sits between datapath producers (register file ports, ALU results, memory read data) and a single downstream consumer. It replaces hard-wired 4:1 combinational selection wherever back-pressure or fair sharing is needed.

---
 rtl/stream_mux_pkg.sv | 13 +
 rtl/stream_mux_rr_arbiter.sv | 53 +++++
 rtl/stream_mux_rr.sv | 110 +++++++++++
 tb/tb_stream_mux_rr.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the stream_mux_rr slice: mode encodings and the
// modulo index helper used by the round-robin search.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Next channel index, wrapping at n.
    function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter for stream_mux_rr: owns the rotating pointer and the
// packet-lock state; the lock pins the grant to the last granted channel.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [NUM_IN-1:0] Req,
    input  logic              Advance,
    input  logic              Lock,
    output logic [NUM_IN-1:0] Grant,
    output logic [SEL_W-1:0]  GrantIdx
);

    logic [SEL_W-1:0] ptr;
    logic             locked;

    // Search starts one past the last granted channel, so it gets lowest priority.
    always_comb begin
        logic [SEL_W-1:0] cand;
        logic             found;
        Grant    = '0;
        GrantIdx = ptr;
        cand     = ptr;
        found    = 1'b0;
        if (locked) begin
            Grant[ptr] = 1'b1;
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                cand = SEL_W'(next_index(32'(cand), NUM_IN));
                if (!found && Req[cand]) begin
                    found       = 1'b1;
                    Grant[cand] = 1'b1;
                    GrantIdx    = cand;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr    <= SEL_W'(NUM_IN - 1);
            locked <= 1'b0;
        end else if (Advance) begin
            ptr    <= GrantIdx;
            locked <= Lock;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-input valid/ready stream mux with a one-entry output register, fixed or
// round-robin selection. Optional packet lock: define STREAM_MUX_LOCK_EN.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int NUM_IN = 4,
    parameter  int WIDTH  = 32,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [NUM_IN*WIDTH-1:0] In,
    input  logic [NUM_IN-1:0]       InValid,
    output logic [NUM_IN-1:0]       InReady,
    input  logic                    Mode,
    input  logic [SEL_W-1:0]        Sel,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [NUM_IN-1:0]       InLast,
    output logic                    OutLast,
`endif
    output logic [WIDTH-1:0]        Out,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [SEL_W-1:0]        OutSrc
);

    logic              free;
    logic [NUM_IN-1:0] rr_grant;
    logic [NUM_IN-1:0] fixed_grant;
    logic [NUM_IN-1:0] xfer;
    logic [SEL_W-1:0]  rr_idx;
    logic              any_xfer;
    logic              advance;
    logic              lock_req;
    logic [WIDTH-1:0]  load_data;
    logic [SEL_W-1:0]  load_src;
`ifdef STREAM_MUX_LOCK_EN
    logic              load_last;
`endif

    assign free = !OutValid || OutReady;

    // An out-of-range Sel matches no channel, so nothing is granted.
    always_comb begin
        fixed_grant = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (Sel == SEL_W'(i)) fixed_grant[i] = 1'b1;
        end
    end

    assign InReady  = free ? ((Mode == MODE_RR) ? rr_grant : fixed_grant) : '0;
    assign xfer     = InReady & InValid;
    assign any_xfer = |xfer;
    assign advance  = (Mode == MODE_RR) && any_xfer;

`ifdef STREAM_MUX_LOCK_EN
    assign lock_req = !InLast[rr_idx];
`else
    assign lock_req = 1'b0;
`endif

    rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .Clock    (Clock),
        .Reset    (Reset),
        .Req      (InValid),
        .Advance  (advance),
        .Lock     (lock_req),
        .Grant    (rr_grant),
        .GrantIdx (rr_idx)
    );

    always_comb begin
        load_data = '0;
        load_src  = '0;
`ifdef STREAM_MUX_LOCK_EN
        load_last = 1'b0;
`endif
        for (int i = 0; i < NUM_IN; i++) begin
            if (xfer[i]) begin
                load_data = In[i*WIDTH +: WIDTH];
                load_src  = SEL_W'(i);
`ifdef STREAM_MUX_LOCK_EN
                load_last = InLast[i];
`endif
            end
        end
    end

    // A reload in the same cycle as a drain keeps OutValid high with no bubble.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Out      <= '0;
            OutSrc   <= '0;
            OutValid <= 1'b0;
`ifdef STREAM_MUX_LOCK_EN
            OutLast  <= 1'b0;
`endif
        end else if (any_xfer) begin
            Out      <= load_data;
            OutSrc   <= load_src;
            OutValid <= 1'b1;
`ifdef STREAM_MUX_LOCK_EN
            OutLast  <= load_last;
`endif
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the mux.
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 2;
    localparam int BW = 1 + SW + W;

    logic           clk;
    logic           reset;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_last;
    logic           out_last;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_src;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: beats held downstream, last loaded beat, RR history.
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] last_beat;
    int            rr_last;
    bit            locked;

    stream_mux_rr #(.NUM_IN(N), .WIDTH(W)) dut (
        .Clock    (clk),
        .Reset    (reset),
        .In       (in_data),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .Mode     (mode),
        .Sel      (sel),
`ifdef STREAM_MUX_LOCK_EN
        .InLast   (in_last),
        .OutLast  (out_last),
`endif
        .Out      (out_data),
        .OutValid (out_valid),
        .OutReady (out_ready),
        .OutSrc   (out_src)
    );

`ifndef STREAM_MUX_LOCK_EN
    assign out_last = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Channel that the spec's rules grant this cycle, or -1 for none.
    function automatic int model_grant();
        if (mode == 1'b0) return (int'(sel) < N) ? int'(sel) : -1;
        if (locked) return rr_last;
        for (int k = 1; k <= N; k++) begin
            if (in_valid[(rr_last + k) % N]) return (rr_last + k) % N;
        end
        return -1;
    endfunction

    task automatic set_data(input int ch, input logic [W-1:0] v);
        in_data[ch*W +: W] = v;
    endtask

    // Entered at a negedge with inputs driven; checks, clocks, updates the model.
    task automatic cycle();
        int            g;
        logic          free;
        logic [N-1:0]  er;
        logic [BW-1:0] ref_b;
        logic [BW-1:0] beat;
        logic          ox;
        logic          ix;
        logic          lb;
        #1;
        g    = model_grant();
        free = (exp_q.size() == 0) || out_ready;
        er   = '0;
        if (g >= 0 && free) er[g] = 1'b1;
        check("in_ready", in_ready, er);
        check("out_valid", out_valid, exp_q.size() != 0);
        ref_b = (exp_q.size() != 0) ? exp_q[0] : last_beat;
        check("out_data", out_data, ref_b[W-1:0]);
        check("out_src", out_src, ref_b[W +: SW]);
`ifdef STREAM_MUX_LOCK_EN
        check("out_last", out_last, ref_b[BW-1]);
        lb = (g >= 0) ? in_last[g] : 1'b0;
`else
        lb = 1'b0;
`endif
        ox = (exp_q.size() != 0) && out_ready;
        ix = (g >= 0) && free && in_valid[g];
        @(posedge clk);
        if (ox) void'(exp_q.pop_front());
        if (ix) begin
            beat = {lb, SW'(g), in_data[g*W +: W]};
            exp_q.push_back(beat);
            last_beat = beat;
            if (mode) begin
                rr_last = g;
`ifdef STREAM_MUX_LOCK_EN
                locked = !lb;
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        exp_q.delete();
        last_beat = '0;
        rr_last   = N - 1;
        locked    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_src", out_src, '0);
        check("rst_last", out_last, 1'b0);
    endtask

    initial begin
        int seq_rr[5]  = '{0, 1, 2, 3, 0};
        int seq_alt[4] = '{1, 3, 1, 3};
        reset = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0;
        in_last = '1; out_ready = 1'b0;
        do_reset();

        // Fixed select of channel 2.
        mode = 1'b0; sel = 2'd2; set_data(2, 32'hDEADBEEF); in_valid = 4'b0100; out_ready = 1'b1;
        #1 check("fix_ready", in_ready, 4'b0100);
        cycle();
        check("fix_data", out_data, 32'hDEADBEEF);
        check("fix_src", out_src, 2'd2);
        check("fix_valid", out_valid, 1'b1);

        // RR with all channels valid from reset.
        do_reset();
        mode = 1'b1; in_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < N; c++) set_data(c, $urandom);
            cycle();
            check("rr_seq", out_src, seq_rr[k]);
        end

        // RR with only channels 1 and 3 valid.
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1 check("rr_skip", in_ready & 4'b0101, 4'b0000);
            cycle();
            check("rr_alt", out_src, seq_alt[k]);
        end

        // Back-pressure then same-cycle reload.
        mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; set_data(0, 32'h11);
        cycle();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_ready", in_ready, 4'b0000);
            cycle();
            check("bp_data", out_data, 32'h11);
            check("bp_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1; set_data(0, 32'h22);
        cycle();
        check("reload_data", out_data, 32'h22);
        check("reload_valid", out_valid, 1'b1);

        // Reset while a beat is held under back-pressure.
        out_ready = 1'b0;
        do_reset();
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        cycle();
        check("post_rst_src", out_src, 2'd0);

`ifdef STREAM_MUX_LOCK_EN
        // Packet lock: channel 1 sends three beats while channel 2 waits.
        begin
            int   lk_src[4]  = '{1, 1, 1, 2};
            logic lk_last[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
            do_reset();
            mode = 1'b1; in_valid = 4'b0110; out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                in_last = 4'b0100;
                in_last[1] = (k == 2);
                cycle();
                check("lock_src", out_src, lk_src[k]);
                check("lock_last", out_last, lk_last[k]);
            end
        end
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) < 2) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 9) == 0) mode = 1'($urandom_range(0, 1));
                sel       = SW'($urandom_range(0, N - 1));
                in_valid  = N'($urandom);
                in_last   = N'($urandom);
                out_ready = ($urandom_range(0, 99) < 70);
                for (int c = 0; c < N; c++) set_data(c, $urandom);
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
